phasenoisepon_nibble_bus_sequencer: RTL and testbench
=====================================================

// Module: phasenoisepon_nibble_bus_sequencer
//
// PURPOSE
// Shares the 2-bit-ctl / 4-bit-data nibble load bus of the seven-segment nibble register
// between NUM_REQ requesters. Round-robin grants one byte-write request at a time, serialises
// it as low-nibble load, high-nibble load and optional exec, then checks the target's status
// echo. Sits between on-chip requesters and the target's io_in[7:2] / io_out[7:0].
//
// PARAMETERS
// NUM_REQ      2   number of requesters, 2..8
// CHECK_STATUS 1   1: compare bus_status against the expected echo; 0: never flag an error
//
// PORTS
// clk          in   1          clock; all state updates on posedge
// reset        in   1          synchronous, active-high
// req_valid    in   NUM_REQ    per-requester request pending
// req_data     in   8*NUM_REQ  byte per requester, requester i in [8*i+7:8*i]
// req_exec     in   NUM_REQ    per-requester: issue an exec beat after the high nibble
// req_ready    out  NUM_REQ    one-hot 1-cycle pulse: request accepted this cycle
// bus_ctl      out  2          target ctl: 00 low nibble, 01 high nibble, 10 exec, 11 idle
// bus_data     out  4          target data nibble
// bus_status   in   8          target output register (echo of previous ctl)
// done_valid   out  1          1-cycle pulse: transaction finished
// done_id      out  3          index of the finished requester
// done_err     out  1          valid with done_valid: status echo mismatched
//
// BEHAVIOUR
// - Reset: state IDLE, RR pointer 0, req_ready=0, bus_ctl=11, bus_data=0, done_valid=0,
//   done_id=0, done_err=0, latched byte/exec/id cleared. Reset mid-transaction aborts it
//   with no done pulse; the target is reset in the same cycle.
// - bus_ctl/bus_data decode from registered state only (Moore); no input-to-bus comb path.
// - Idle code is 11. The target treats it as a stub op and echoes 0xFF. 00 is never idle,
//   because 00 loads the low nibble.
// - States and bus drive:
//   IDLE: ctl=11, data=0. If any req_valid: grant by round-robin, starting at pointer.
//     Pulse req_ready[g]; latch req_data[g], req_exec[g] and g; pointer <= (g+1) mod NUM_REQ.
//     Next state LO. With no request: stay IDLE.
//   LO:   ctl=00, data=byte[3:0] -> HI.
//   HI:   ctl=01, data=byte[7:4]. Expect bus_status==8'h0F. Next: EX if exec, else CHK.
//   EX:   ctl=10, data=0. Expect bus_status==8'hF0 -> CHK.
//   CHK:  ctl=11, data=0. Expect bus_status==8'hFF if exec, else 8'hF0.
//     Pulse done_valid with done_id and done_err -> IDLE.
// - Error: any expectation miss (CHECK_STATUS=1) sets a sticky err bit for the transaction.
//   The sequence is not shortened, so bus timing is deterministic. err clears on the next grant.
// - Latency from the req_ready cycle t: done at t+3 without exec, t+4 with exec. The next
//   grant is no earlier than t+4 or t+5. Throughput is 1 byte per 4 or 5 cycles.
// - Request changes: req_valid/req_data changing while not granted has no effect. The latched
//   copy is immune to input changes after the grant. A requester holding valid after its ready
//   pulse is treated as a new request.
// - Simultaneous requests: the lowest index at or after the pointer wins. Pointer wrap
//   NUM_REQ-1 -> 0.
// - done_id is zero-extended for NUM_REQ<8. Bits at index >= NUM_REQ never assert.
//
// STRUCTURE
// - Shared package phasenoisepon_nibble_pkg: CTL_LOW=2'b00, CTL_HIGH=2'b01, CTL_EXEC=2'b10,
//   CTL_IDLE=2'b11, STAT_LOW=8'h0F, STAT_HIGH=8'hF0, STAT_IDLE=8'hFF, state encoding.
//   The same constants are used by the nibble register decode.
// - One sub-module: phasenoisepon_rr_arbiter. Inputs: NUM_REQ-wide req, pointer. Outputs:
//   one-hot grant, binary index, any. Purely combinational. The FSM owns the pointer register.
//
// TESTING (bench instantiates this block driving the real nibble register)
// 1. Reset, then req0 data=8'hA5 exec=0 -> ready0 at t; bus 00/5, 01/A, 11/0.
//    done at t+3 with id=0, err=0. Target holds low=5, high=A.
// 2. req1 data=8'h3C exec=1 -> bus 00/C, 01/3, 10/0, 11/0. done at t+4 with id=1, err=0.
// 3. req0 and req1 held continuously, 4 grants -> order 0,1,0,1. Gap between ready pulses is
//    4 cycles. Pointer wraps correctly.
// 4. Force bus_status=8'h00 during HI -> full sequence still driven; done_err=1.
//    The next clean transaction reports err=0. With CHECK_STATUS=0 -> err=0.
// 5. Assert reset in state HI -> next cycle ctl=11, data=0, no done pulse.
//    A pending req0 is then granted normally.
// 6. Change req_data[7:0] from 8'h11 to 8'hEE the cycle after ready0 -> bus still
//    carries 1/1; done_valid only once.

Source files
------------

// File: rtl/phasenoisepon_nibble_bus_sequencer_pkg.sv
// Shared nibble-bus encodings: ctl codes, the status echo the nibble register returns for each,
// and the sequencer state encoding.
package phasenoisepon_nibble_pkg;

    localparam logic [1:0] CTL_LOW  = 2'b00;
    localparam logic [1:0] CTL_HIGH = 2'b01;
    localparam logic [1:0] CTL_EXEC = 2'b10;
    localparam logic [1:0] CTL_IDLE = 2'b11;

    localparam logic [7:0] STAT_LOW  = 8'h0F;
    localparam logic [7:0] STAT_HIGH = 8'hF0;
    localparam logic [7:0] STAT_IDLE = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LO   = 3'd1,
        ST_HI   = 3'd2,
        ST_EX   = 3'd3,
        ST_CHK  = 3'd4
    } seq_state_e;

    // Status the target presents one cycle after it was driven with the given ctl.
    function automatic logic [7:0] ctl_echo(input logic [1:0] ctl);
        logic [7:0] echo;
        unique case (ctl)
            CTL_LOW:  echo = STAT_LOW;
            CTL_HIGH: echo = STAT_HIGH;
            default:  echo = STAT_IDLE;
        endcase
        return echo;
    endfunction

endpackage

// File: rtl/phasenoisepon_nibble_bus_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: the lowest requesting index at or after ptr_i wins.
// The pointer register lives in the owning FSM.
module phasenoisepon_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    // NOTE: every output and temporary gets a default before the loop, so no latch is inferred.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr_i} + (IDX_W + 1)'(i);
            if (sum >= NUM_REQ_W) begin
                sum = sum - NUM_REQ_W;
            end
            cand = sum[IDX_W-1:0];
            if (!any_o && req_i[cand]) begin
                any_o         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

endmodule

// File: rtl/phasenoisepon_nibble_bus_sequencer.sv
// Round-robin sequencer sharing the nibble-register load bus: each granted byte becomes
// low-nibble load, high-nibble load, optional exec, then a status-echo check.
module phasenoisepon_nibble_bus_sequencer
    import phasenoisepon_nibble_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter bit CHECK_STATUS = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_exec,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [1:0]           bus_ctl,
    output logic [3:0]           bus_data,
    input  logic [7:0]           bus_status,
    output logic                 done_valid,
    output logic [2:0]           done_id,
    output logic                 done_err
);

    localparam int IDX_W = $clog2(NUM_REQ);

    seq_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [7:0]       byte_q, byte_d;
    logic             exec_q, exec_d;
    logic [IDX_W-1:0] id_q, id_d;
    logic             err_q, err_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;

    logic [7:0] expect_stat;
    logic       check_en;
    logic       miss;

    phasenoisepon_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    // Each check looks at the echo of the ctl code driven in the previous state.
    always_comb begin
        expect_stat = STAT_IDLE;
        check_en    = 1'b0;
        unique case (state_q)
            ST_HI: begin
                expect_stat = ctl_echo(CTL_LOW);
                check_en    = 1'b1;
            end
            ST_EX: begin
                expect_stat = ctl_echo(CTL_HIGH);
                check_en    = 1'b1;
            end
            ST_CHK: begin
                expect_stat = exec_q ? ctl_echo(CTL_EXEC) : ctl_echo(CTL_HIGH);
                check_en    = 1'b1;
            end
            default: ;
        endcase
        miss = CHECK_STATUS && check_en && (bus_status != expect_stat);
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        byte_d     = byte_q;
        exec_d     = exec_q;
        id_d       = id_q;
        err_d      = err_q;
        req_ready  = '0;
        done_valid = 1'b0;
        done_err   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_any && !reset) begin
                    req_ready = arb_grant;
                    byte_d    = req_data[{arb_idx, 3'b000} +: 8];
                    exec_d    = req_exec[arb_idx];
                    id_d      = arb_idx;
                    err_d     = 1'b0;
                    ptr_d     = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                    state_d   = ST_LO;
                end
            end
            ST_LO: state_d = ST_HI;
            ST_HI: begin
                err_d   = err_q | miss;
                state_d = exec_q ? ST_EX : ST_CHK;
            end
            ST_EX: begin
                err_d   = err_q | miss;
                state_d = ST_CHK;
            end
            ST_CHK: begin
                done_valid = !reset;
                done_err   = err_q | miss;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        done_id              = '0;
        done_id[IDX_W-1:0]   = id_q;
    end

    // Bus drive depends on registered state only.
    always_comb begin
        bus_ctl  = CTL_IDLE;
        bus_data = 4'h0;
        unique case (state_q)
            ST_LO: begin
                bus_ctl  = CTL_LOW;
                bus_data = byte_q[3:0];
            end
            ST_HI: begin
                bus_ctl  = CTL_HIGH;
                bus_data = byte_q[7:4];
            end
            ST_EX:   bus_ctl = CTL_EXEC;
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            byte_q  <= '0;
            exec_q  <= 1'b0;
            id_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            byte_q  <= byte_d;
            exec_q  <= exec_d;
            id_q    <= id_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_phasenoisepon_nibble_bus_sequencer.sv
// Scoreboard bench: a behavioural nibble register answers the bus; each grant queues the
// expected bus beats and done result, popped and compared one per cycle on the falling edge.
module tb_phasenoisepon_nibble_bus_sequencer;

    localparam int N = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid, req_exec, req_ready, nc_req_ready;
    logic [8*N-1:0] req_data;
    logic [1:0]     bus_ctl, nc_bus_ctl;
    logic [3:0]     bus_data, nc_bus_data;
    logic [7:0]     bus_status, tgt_status;
    logic [3:0]     tgt_lo, tgt_hi;
    logic           done_valid, done_err, nc_done_valid, nc_done_err;
    logic [2:0]     done_id, nc_done_id;

    typedef struct {
        logic [1:0] ctl;
        logic [3:0] data;
        bit         last;
        int         id;
        bit         err;
    } beat_t;

    beat_t beats[$];
    int    grant_log[$];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    ptr_m = 0;
    int    last_ready_cyc = -1;
    int    done_count = 0;
    bit    mon_en = 1'b0;
    bit    force_zero = 1'b0;
    bit    gap_chk = 1'b0;
    bit    last_done_err = 1'b0;

    always #5 clk = ~clk;

    phasenoisepon_nibble_bus_sequencer #(.NUM_REQ(N), .CHECK_STATUS(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_exec   (req_exec),
        .req_ready  (req_ready),
        .bus_ctl    (bus_ctl),
        .bus_data   (bus_data),
        .bus_status (bus_status),
        .done_valid (done_valid),
        .done_id    (done_id),
        .done_err   (done_err)
    );

    phasenoisepon_nibble_bus_sequencer #(.NUM_REQ(N), .CHECK_STATUS(1'b0)) dut_nc (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_exec   (req_exec),
        .req_ready  (nc_req_ready),
        .bus_ctl    (nc_bus_ctl),
        .bus_data   (nc_bus_data),
        .bus_status (bus_status),
        .done_valid (nc_done_valid),
        .done_id    (nc_done_id),
        .done_err   (nc_done_err)
    );

    // Nibble register model: echoes the previous ctl, optionally corrupted during the high load.
    assign bus_status = (force_zero && bus_ctl == 2'b01) ? 8'h00 : tgt_status;

    always @(posedge clk) begin
        if (reset) begin
            tgt_status <= 8'hFF;
            tgt_lo     <= 4'h0;
            tgt_hi     <= 4'h0;
        end else begin
            case (bus_ctl)
                2'b00: begin
                    tgt_status <= 8'h0F;
                    tgt_lo     <= bus_data;
                end
                2'b01: begin
                    tgt_status <= 8'hF0;
                    tgt_hi     <= bus_data;
                end
                default: tgt_status <= 8'hFF;
            endcase
        end
    end

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            beats.delete();
            ptr_m = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        logic [N-1:0] exp_ready;
        logic [7:0]   d;
        int           g;
        int           c;
        beat_t        b;
        beat_t        nb;
        if (mon_en) begin
            exp_ready = '0;
            g = -1;
            if (beats.size() == 0 && !reset && |req_valid) begin
                for (int k = 0; k < N; k++) begin
                    c = (ptr_m + k) % N;
                    if (g < 0 && req_valid[c]) g = c;
                end
            end
            if (g >= 0) exp_ready[g] = 1'b1;
            check("req_ready", req_ready, exp_ready);
            check("nc_req_ready", nc_req_ready, exp_ready);

            if (beats.size() != 0) begin
                b = beats.pop_front();
            end else begin
                b = '{ctl: 2'b11, data: 4'h0, last: 1'b0, id: 0, err: 1'b0};
            end
            check("bus_ctl", bus_ctl, b.ctl);
            check("bus_data", bus_data, b.data);
            check("nc_bus_ctl", nc_bus_ctl, b.ctl);
            check("nc_bus_data", nc_bus_data, b.data);
            check("done_valid", done_valid, b.last);
            check("nc_done_valid", nc_done_valid, b.last);
            if (b.last && done_valid) begin
                check("done_id", done_id, b.id);
                check("done_err", done_err, b.err);
                check("nc_done_id", nc_done_id, b.id);
                check("nc_done_err", nc_done_err, 0);
                last_done_err = done_err;
                done_count++;
            end

            if (g >= 0) begin
                d  = req_data[8*g +: 8];
                nb = '{ctl: 2'b00, data: d[3:0], last: 1'b0, id: g, err: 1'b0};
                beats.push_back(nb);
                nb = '{ctl: 2'b01, data: d[7:4], last: 1'b0, id: g, err: 1'b0};
                beats.push_back(nb);
                if (req_exec[g]) begin
                    nb = '{ctl: 2'b10, data: 4'h0, last: 1'b0, id: g, err: 1'b0};
                    beats.push_back(nb);
                end
                nb = '{ctl: 2'b11, data: 4'h0, last: 1'b1, id: g, err: force_zero};
                beats.push_back(nb);
                ptr_m = (g + 1) % N;
                if (gap_chk && last_ready_cyc >= 0) check("ready_gap", cyc - last_ready_cyc, 4);
                last_ready_cyc = cyc;
                grant_log.push_back(g);
            end
        end
    end

    task automatic wait_ready(input int id);
        bit got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (req_ready[id]) got = 1'b1;
        end
        check("ready_timeout", got, 1);
    endtask

    task automatic send(input int id, input logic [7:0] d, input logic e);
        @(posedge clk); #1;
        req_valid[id]       = 1'b1;
        req_data[8*id +: 8] = d;
        req_exec[id]        = e;
        wait_ready(id);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int k = 0; k < 40 && !idle; k++) begin
            @(posedge clk);
            if (beats.size() == 0) idle = 1'b1;
        end
        check("idle_timeout", idle, 1);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int exp_order[4];
        int dc;
        exp_order = '{0, 1, 0, 1};
        reset     = 1'b1;
        req_valid = '0;
        req_exec  = '0;
        req_data  = '0;
        @(posedge clk);
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("rst_ctl", bus_ctl, 2'b11);
        check("rst_data", bus_data, 4'h0);
        check("rst_ready", req_ready, 2'b00);
        check("rst_done_valid", done_valid, 0);
        check("rst_done_id", done_id, 0);
        check("rst_done_err", done_err, 0);

        // Plain byte write, then one with an exec beat.
        send(0, 8'hA5, 1'b0);
        wait_idle();
        check("t1_tgt_lo", tgt_lo, 4'h5);
        check("t1_tgt_hi", tgt_hi, 4'hA);
        send(1, 8'h3C, 1'b1);
        wait_idle();
        check("t2_tgt_lo", tgt_lo, 4'hC);
        check("t2_tgt_hi", tgt_hi, 4'h3);

        // Both requesters held: alternating grants every 4 cycles.
        grant_log.delete();
        last_ready_cyc = -1;
        gap_chk = 1'b1;
        @(posedge clk); #1;
        req_data  = {8'h21, 8'h10};
        req_exec  = 2'b00;
        req_valid = 2'b11;
        for (int k = 0; k < 60 && grant_log.size() < 4; k++) @(posedge clk);
        #1 req_valid = 2'b00;
        gap_chk = 1'b0;
        check("t3_grants", grant_log.size(), 4);
        if (grant_log.size() >= 4) begin
            for (int k = 0; k < 4; k++) check("t3_order", grant_log[k], exp_order[k]);
        end
        wait_idle();

        // Corrupted echo during the high load, then a clean transaction.
        force_zero = 1'b1;
        send(0, 8'h5A, 1'b0);
        wait_idle();
        force_zero = 1'b0;
        check("t4_err", last_done_err, 1);
        send(1, 8'h96, 1'b0);
        wait_idle();
        check("t4_clean_err", last_done_err, 0);

        // Reset during the high-nibble beat aborts the transaction.
        dc = done_count;
        @(posedge clk); #1;
        req_valid[0]  = 1'b1;
        req_data[7:0] = 8'h77;
        req_exec[0]   = 1'b0;
        wait_ready(0);
        @(posedge clk); #1 req_valid[0] = 1'b0;
        @(posedge clk); #1;
        check("t5_in_hi", bus_ctl, 2'b01);
        reset         = 1'b1;
        req_valid[0]  = 1'b1;
        req_data[7:0] = 8'h42;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("t5_ctl", bus_ctl, 2'b11);
        check("t5_data", bus_data, 4'h0);
        check("t5_regrant", req_ready[0], 1);
        @(posedge clk); #1 req_valid[0] = 1'b0;
        wait_idle();
        check("t5_done_count", done_count - dc, 1);
        check("t5_tgt_lo", tgt_lo, 4'h2);

        // Input change right after the grant must not reach the bus.
        dc = done_count;
        @(posedge clk); #1;
        req_valid[0]  = 1'b1;
        req_data[7:0] = 8'h11;
        wait_ready(0);
        @(posedge clk); #1;
        req_data[7:0] = 8'hEE;
        req_valid[0]  = 1'b0;
        wait_idle();
        repeat (4) @(posedge clk);
        check("t6_done_once", done_count - dc, 1);
        check("t6_tgt_lo", tgt_lo, 4'h1);
        check("t6_tgt_hi", tgt_hi, 4'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
